sample_recorder: RTL and testbench

- Write-side counterpart of the sample playback address path: captures a stream of incoming audio samples into a sample BRAM, starting at address 0.
- Reports the recorded length so playback can loop over only the valid region.
- Sits between the audio input/ADC sample stream and port A (write) of the sample BRAM; the playback reader uses port B.

---
 rtl/sample_recorder.sv | 143 ++++++++++++++
 tb/tb_sample_recorder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_recorder.sv
// Captures a gated sample stream into BRAM port A from address 0 and reports take length.
// Optional SAMPLE_RECORDER_TRIGGER_EN adds an ARMED state that waits for a level trigger.
module sample_recorder #(
    parameter int BRAM_DEPTH = 8192,
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 8,
    parameter int TRIG_LEVEL = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  record_in,
    input  logic                  sample_valid_in,
    input  logic [DATA_WIDTH-1:0] sample_in,
    output logic                  bram_we_out,
    output logic [ADDR_WIDTH-1:0] bram_addr_out,
    output logic [DATA_WIDTH-1:0] bram_din_out,
    output logic                  recording_out,
    output logic                  done_out,
    output logic                  full_out,
    output logic [ADDR_WIDTH:0]   sample_len_out
);

    typedef enum logic [1:0] {IDLE, ARMED, RECORD, DONE} state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(BRAM_DEPTH);

    state_t              state;
    state_t              state_nx;
    logic                rec_q;
    logic                rise;
    logic                start;
    logic                accept;
    logic                last;
    logic [ADDR_WIDTH:0] ptr;

`ifdef SAMPLE_RECORDER_TRIGGER_EN
    localparam logic signed [DATA_WIDTH:0] MID =
        (DATA_WIDTH+1)'(1 << (DATA_WIDTH-1));
    localparam logic signed [DATA_WIDTH:0] TRIG_S =
        (DATA_WIDTH+1)'(TRIG_LEVEL);

    logic signed [DATA_WIDTH:0] diff;
    logic signed [DATA_WIDTH:0] mag;
    logic                       trig_hit;

    always_comb begin
        diff     = $signed({1'b0, sample_in}) - MID;
        mag      = (diff < 0) ? -diff : diff;
        trig_hit = (mag >= TRIG_S);
    end
`endif

    assign rise = record_in & ~rec_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        accept   = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    start = 1'b1;
`ifdef SAMPLE_RECORDER_TRIGGER_EN
                    state_nx = ARMED;
`else
                    state_nx = RECORD;
`endif
                end
            end
            ARMED: begin
`ifdef SAMPLE_RECORDER_TRIGGER_EN
                if (!record_in) begin
                    state_nx = DONE;
                end else if (sample_valid_in && trig_hit) begin
                    accept   = 1'b1;
                    state_nx = RECORD;
                end
`else
                state_nx = IDLE;
`endif
            end
            RECORD: begin
                if (!record_in) begin
                    state_nx = DONE;
                end else if (sample_valid_in) begin
                    accept = 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        // Filling the last BRAM word ends the take regardless of record_in.
        last = accept && (ptr == DEPTH_CNT - 1'b1);
        if (last) begin
            state_nx = DONE;
        end
    end

    assign recording_out = (state == RECORD) || (state == ARMED);
    assign done_out      = (state == DONE);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rec_q          <= 1'b0;
            ptr            <= '0;
            bram_we_out    <= 1'b0;
            bram_addr_out  <= '0;
            bram_din_out   <= '0;
            sample_len_out <= '0;
            full_out       <= 1'b0;
        end else begin
            rec_q       <= record_in;
            bram_we_out <= accept;
            if (accept) begin
                bram_addr_out <= ptr[ADDR_WIDTH-1:0];
                bram_din_out  <= sample_in;
                ptr           <= ptr + 1'b1;
            end
            if (start) begin
                ptr            <= '0;
                sample_len_out <= '0;
                full_out       <= 1'b0;
            end
            if (state_nx == DONE && state != DONE) begin
                sample_len_out <= accept ? ptr + 1'b1 : ptr;
                full_out       <= last;
            end
        end
    end

endmodule

// File: tb/tb_sample_recorder.sv
// Directed bench for sample_recorder with a take-level reference model.
module tb_sample_recorder;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int TRIG  = 16;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          record_in = 1'b0;
    logic          sample_valid_in = 1'b0;
    logic [DW-1:0] sample_in = '0;
    logic          bram_we_out;
    logic [AW-1:0] bram_addr_out;
    logic [DW-1:0] bram_din_out;
    logic          recording_out;
    logic          done_out;
    logic          full_out;
    logic [AW:0]   sample_len_out;

    int n_chk = 0;
    int n_fail = 0;

    sample_recorder #(
        .BRAM_DEPTH(DEPTH),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TRIG_LEVEL(TRIG)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .record_in(record_in),
        .sample_valid_in(sample_valid_in),
        .sample_in(sample_in),
        .bram_we_out(bram_we_out),
        .bram_addr_out(bram_addr_out),
        .bram_din_out(bram_din_out),
        .recording_out(recording_out),
        .done_out(done_out),
        .full_out(full_out),
        .sample_len_out(sample_len_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: tracks a take as a count of accepted samples.
    bit      m_take = 0;
    bit      m_armed = 0;
    bit      prev_rec = 0;
    int      m_cnt = 0;
    bit      exp_we = 0;
    int      exp_addr = 0;
    int      exp_din = 0;
    bit      exp_done = 0;
    bit      exp_full = 0;
    int      exp_len = 0;
    bit      trig_on;

`ifdef SAMPLE_RECORDER_TRIGGER_EN
    initial trig_on = 1;
`else
    initial trig_on = 0;
`endif

    function automatic bit trig_ok(input int s);
        int d;
        d = s - 128;
        if (d < 0) d = -d;
        return d >= TRIG;
    endfunction

    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            m_take = 0; m_armed = 0; prev_rec = 0; m_cnt = 0;
            exp_we = 0; exp_addr = 0; exp_din = 0;
            exp_done = 0; exp_full = 0; exp_len = 0;
        end else begin
            bit in_done;
            in_done  = exp_done;
            exp_we   = 0;
            exp_done = 0;
            if (m_take) begin
                if (!record_in) begin
                    m_take = 0; exp_done = 1; exp_len = m_cnt;
                end else if (sample_valid_in &&
                             (!m_armed || trig_ok(int'(sample_in)))) begin
                    exp_we = 1; exp_addr = m_cnt; exp_din = int'(sample_in);
                    m_cnt++; m_armed = 0;
                    if (m_cnt == DEPTH) begin
                        m_take = 0; exp_done = 1;
                        exp_len = DEPTH; exp_full = 1;
                    end
                end
            end else if (!in_done && record_in && !prev_rec) begin
                m_take = 1; m_cnt = 0; exp_len = 0;
                exp_full = 0; m_armed = trig_on;
            end
            prev_rec = record_in;
        end
    end

    int wa[$];
    int wd[$];
    int done_cnt = 0;
    bit cmp_en = 0;

    always @(negedge clk_in) begin
        if (cmp_en) begin
            chk("we", 32'(bram_we_out), 32'(exp_we));
            chk("addr", 32'(bram_addr_out), exp_addr);
            chk("din", 32'(bram_din_out), exp_din);
            chk("recording", 32'(recording_out), 32'(m_take));
            chk("done", 32'(done_out), 32'(exp_done));
            chk("full", 32'(full_out), 32'(exp_full));
            chk("len", 32'(sample_len_out), exp_len);
        end
        if (bram_we_out) begin
            wa.push_back(int'(bram_addr_out));
            wd.push_back(int'(bram_din_out));
        end
        if (done_out) done_cnt++;
    end

    task automatic step(input bit r, input bit v, input int s);
        @(negedge clk_in);
        record_in       = r;
        sample_valid_in = v;
        sample_in       = DW'(s);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0);
    endtask

    task automatic clr();
        wa.delete();
        wd.delete();
        done_cnt = 0;
    endtask

    initial begin
        #1 rst_in = 1;
        #2;
        chk("rst_we", 32'(bram_we_out), 0);
        chk("rst_len", 32'(sample_len_out), 0);
        chk("rst_rec", 32'(recording_out), 0);
        repeat (3) @(negedge clk_in);
        rst_in = 0;
        cmp_en = 1;
        idle(2);

        // Five samples then release.
        clr();
        step(1, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 'h10 + i);
        step(0, 0, 0);
        idle(3);
        chk("t1_nwr", wa.size(), 5);
        chk("t1_addr4", wa[4], 4);
        chk("t1_din4", wd[4], 'h14);
        chk("t1_done", done_cnt, 1);
        chk("t1_len", 32'(sample_len_out), 5);
        chk("t1_full", 32'(full_out), 0);

        // Overfill with record held high.
        clr();
        step(1, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 1, 'h20 + i);
        repeat (4) step(1, 0, 0);
        chk("t2_norestart", 32'(recording_out), 0);
        step(0, 0, 0);
        idle(2);
        chk("t2_nwr", wa.size(), 8);
        chk("t2_addr7", wa[7], 7);
        chk("t2_din7", wd[7], 'h27);
        chk("t2_len", 32'(sample_len_out), 8);
        chk("t2_full", 32'(full_out), 1);
        chk("t2_done", done_cnt, 1);

        // Strobe coincident with release is dropped.
        clr();
        step(1, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 'h30 + i);
        step(0, 1, 'h33);
        idle(3);
        chk("t3_nwr", wa.size(), 3);
        chk("t3_len", 32'(sample_len_out), 3);
        chk("t3_full", 32'(full_out), 0);

        // Async reset with a write pending.
        clr();
        step(1, 0, 0);
        step(1, 1, 'h40);
        step(1, 1, 'h41);
        @(posedge clk_in);
        #2 rst_in = 1;
        #1;
        chk("t4_we", 32'(bram_we_out), 0);
        chk("t4_addr", 32'(bram_addr_out), 0);
        chk("t4_rec", 32'(recording_out), 0);
        chk("t4_len", 32'(sample_len_out), 0);
        @(negedge clk_in);
        record_in = 0;
        sample_valid_in = 0;
        rst_in = 0;
        idle(1);
        clr();
        step(1, 0, 0);
        step(1, 1, 'h50);
        step(0, 0, 0);
        idle(2);
        chk("t4_nwr", wa.size(), 1);
        chk("t4_addr0", wa[0], 0);
        chk("t4_len2", 32'(sample_len_out), 1);

        // Zero-length take.
        clr();
        repeat (4) step(1, 0, 0);
        step(0, 0, 0);
        idle(3);
        chk("t5_nwr", wa.size(), 0);
        chk("t5_done", done_cnt, 1);
        chk("t5_len", 32'(sample_len_out), 0);

`ifdef SAMPLE_RECORDER_TRIGGER_EN
        clr();
        step(1, 0, 0);
        step(1, 1, 'h80);
        step(1, 1, 'h85);
        step(1, 1, 'h6F);
        step(1, 1, 'h81);
        step(0, 0, 0);
        idle(3);
        chk("t6_nwr", wa.size(), 2);
        chk("t6_a0", wa[0], 0);
        chk("t6_d0", wd[0], 'h6F);
        chk("t6_a1", wa[1], 1);
        chk("t6_d1", wd[1], 'h81);
        chk("t6_len", 32'(sample_len_out), 2);
`endif

        cmp_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
